// File: rtl/mem_stage_hs_if.sv
// rtl/mem_stage_hs_if.sv - upstream, data-memory and writeback bundle for the memory stage
interface mem_stage_hs_if;
   // upstream instruction handshake
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  op;
   logic [31:0] alu_result;
   logic [31:0] store_data;
   logic [4:0]  wreg;
   logic        regwrite;
   // data-memory request/ack bus
   logic        dm_req;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [3:0]  dm_be;
   logic [31:0] dm_wdata;
   logic        dm_ack;
   logic [31:0] dm_rdata;
   // writeback result
   logic        wb_valid;
   logic [4:0]  wb_reg;
   logic        wb_regwrite;
   logic [31:0] wb_data;
   logic [1:0]  wb_err;

   // environment side: drives instructions and memory responses
   modport master (
      output in_valid, op, alu_result, store_data, wreg, regwrite, dm_ack, dm_rdata,
      input  in_ready, dm_req, dm_we, dm_addr, dm_be, dm_wdata,
      input  wb_valid, wb_reg, wb_regwrite, wb_data, wb_err
   );

   // stage side
   modport slave (
      input  in_valid, op, alu_result, store_data, wreg, regwrite, dm_ack, dm_rdata,
      output in_ready, dm_req, dm_we, dm_addr, dm_be, dm_wdata,
      output wb_valid, wb_reg, wb_regwrite, wb_data, wb_err
   );
endinterface

// File: rtl/mem_stage_hs.sv
// rtl/mem_stage_hs.sv - pipeline memory stage with data-memory handshake and timeout
module mem_stage_hs #(
   parameter int BIG_ENDIAN = 1,
   parameter int TIMEOUT    = 256
) (
   input  logic          CLK,
   input  logic          RESET,
   mem_stage_hs_if.slave bus
);

   typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

   localparam logic [3:0] OP_LB  = 4'd1;
   localparam logic [3:0] OP_LBU = 4'd2;
   localparam logic [3:0] OP_LH  = 4'd3;
   localparam logic [3:0] OP_LHU = 4'd4;
   localparam logic [3:0] OP_LW  = 4'd5;
   localparam logic [3:0] OP_SB  = 4'd6;
   localparam logic [3:0] OP_SH  = 4'd7;
   localparam logic [3:0] OP_SW  = 4'd8;

   localparam logic [1:0] ERR_OK      = 2'd0;
   localparam logic [1:0] ERR_ALIGN   = 2'd1;
   localparam logic [1:0] ERR_TIMEOUT = 2'd2;

   localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

   // Physical byte position (from LSB) of the byte at address offset k.
   function automatic logic [1:0] byte_pos(input logic [1:0] k);
      return (BIG_ENDIAN != 0) ? ~k : k;
   endfunction

   // Physical byte position of the low-order byte of the halfword at even offset k.
   function automatic logic [1:0] half_pos(input logic [1:0] k);
      return (BIG_ENDIAN != 0) ? {~k[1], 1'b0} : {k[1], 1'b0};
   endfunction

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [3:0]  op_q, op_d;
   logic [1:0]  off_q, off_d;
   logic [4:0]  wreg_q, wreg_d;
   logic        regwrite_q, regwrite_d;
   logic        dm_req_q, dm_req_d;
   logic        dm_we_q, dm_we_d;
   logic [31:0] dm_addr_q, dm_addr_d;
   logic [3:0]  dm_be_q, dm_be_d;
   logic [31:0] dm_wdata_q, dm_wdata_d;
   logic        wb_valid_q, wb_valid_d;
   logic [4:0]  wb_reg_q, wb_reg_d;
   logic        wb_regwrite_q, wb_regwrite_d;
   logic [31:0] wb_data_q, wb_data_d;
   logic [1:0]  wb_err_q, wb_err_d;

   logic        in_is_load, in_is_store, in_misaligned;
   logic        q_is_load;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] load_val;

   assign bus.in_ready    = (state_q == IDLE);
   assign bus.dm_req      = dm_req_q;
   assign bus.dm_we       = dm_we_q;
   assign bus.dm_addr     = dm_addr_q;
   assign bus.dm_be       = dm_be_q;
   assign bus.dm_wdata    = dm_wdata_q;
   assign bus.wb_valid    = wb_valid_q;
   assign bus.wb_reg      = wb_reg_q;
   assign bus.wb_regwrite = wb_regwrite_q;
   assign bus.wb_data     = wb_data_q;
   assign bus.wb_err      = wb_err_q;

   // Decode the incoming op and extract/extend the load value from the returned word.
   always_comb begin
      in_is_load    = (bus.op >= OP_LB) && (bus.op <= OP_LW);
      in_is_store   = (bus.op >= OP_SB) && (bus.op <= OP_SW);
      in_misaligned = 1'b0;
      case (bus.op)
         OP_LH, OP_LHU, OP_SH: in_misaligned = bus.alu_result[0];
         OP_LW, OP_SW:         in_misaligned = (bus.alu_result[1:0] != 2'b00);
         default:              in_misaligned = 1'b0;
      endcase

      q_is_load = (op_q >= OP_LB) && (op_q <= OP_LW);
      ld_byte   = 8'(bus.dm_rdata >> {byte_pos(off_q), 3'b000});
      ld_half   = 16'(bus.dm_rdata >> {half_pos(off_q), 3'b000});
      case (op_q)
         OP_LB:   load_val = {{24{ld_byte[7]}}, ld_byte};
         OP_LBU:  load_val = {24'h0, ld_byte};
         OP_LH:   load_val = {{16{ld_half[15]}}, ld_half};
         OP_LHU:  load_val = {16'h0, ld_half};
         OP_LW:   load_val = bus.dm_rdata;
         default: load_val = 32'h0;
      endcase
   end

   // Next-state and output computation for the IDLE/WAIT handshake machine.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      op_d          = op_q;
      off_d         = off_q;
      wreg_d        = wreg_q;
      regwrite_d    = regwrite_q;
      dm_req_d      = dm_req_q;
      dm_we_d       = dm_we_q;
      dm_addr_d     = dm_addr_q;
      dm_be_d       = dm_be_q;
      dm_wdata_d    = dm_wdata_q;
      wb_valid_d    = 1'b0;
      wb_reg_d      = wb_reg_q;
      wb_regwrite_d = wb_regwrite_q;
      wb_data_d     = wb_data_q;
      wb_err_d      = wb_err_q;

      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               op_d       = bus.op;
               off_d      = bus.alu_result[1:0];
               wreg_d     = bus.wreg;
               regwrite_d = bus.regwrite;
               if (!in_is_load && !in_is_store) begin
                  // pass-through result completes at the accept edge
                  wb_valid_d    = 1'b1;
                  wb_reg_d      = bus.wreg;
                  wb_regwrite_d = bus.regwrite;
                  wb_data_d     = bus.alu_result;
                  wb_err_d      = ERR_OK;
               end else if (in_misaligned) begin
                  // rejected without touching memory
                  wb_valid_d    = 1'b1;
                  wb_reg_d      = bus.wreg;
                  wb_regwrite_d = 1'b0;
                  wb_data_d     = 32'h0;
                  wb_err_d      = ERR_ALIGN;
               end else begin
                  state_d    = WAIT;
                  cnt_d      = 16'h0;
                  dm_req_d   = 1'b1;
                  dm_we_d    = in_is_store;
                  dm_addr_d  = {bus.alu_result[31:2], 2'b00};
                  dm_be_d    = 4'b1111;
                  dm_wdata_d = 32'h0;
                  case (bus.op)
                     OP_SB: begin
                        dm_be_d    = 4'b0001 << byte_pos(bus.alu_result[1:0]);
                        dm_wdata_d = {4{bus.store_data[7:0]}};
                     end
                     OP_SH: begin
                        dm_be_d    = 4'b0011 << half_pos(bus.alu_result[1:0]);
                        dm_wdata_d = {2{bus.store_data[15:0]}};
                     end
                     OP_SW: begin
                        dm_wdata_d = bus.store_data;
                     end
                     default: ;
                  endcase
               end
            end
         end
         WAIT: begin
            if (bus.dm_ack) begin
               // ack wins even on the cycle the timeout would fire
               state_d       = IDLE;
               dm_req_d      = 1'b0;
               wb_valid_d    = 1'b1;
               wb_reg_d      = wreg_q;
               wb_regwrite_d = q_is_load ? regwrite_q : 1'b0;
               wb_data_d     = q_is_load ? load_val : 32'h0;
               wb_err_d      = ERR_OK;
            end else if (cnt_q == CNT_LAST) begin
               state_d       = IDLE;
               dm_req_d      = 1'b0;
               wb_valid_d    = 1'b1;
               wb_reg_d      = wreg_q;
               wb_regwrite_d = 1'b0;
               wb_data_d     = 32'h0;
               wb_err_d      = ERR_TIMEOUT;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers; reset abandons any in-flight request.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q       <= IDLE;
         cnt_q         <= 16'h0;
         op_q          <= 4'h0;
         off_q         <= 2'b00;
         wreg_q        <= 5'h0;
         regwrite_q    <= 1'b0;
         dm_req_q      <= 1'b0;
         dm_we_q       <= 1'b0;
         dm_addr_q     <= 32'h0;
         dm_be_q       <= 4'h0;
         dm_wdata_q    <= 32'h0;
         wb_valid_q    <= 1'b0;
         wb_reg_q      <= 5'h0;
         wb_regwrite_q <= 1'b0;
         wb_data_q     <= 32'h0;
         wb_err_q      <= 2'b00;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         op_q          <= op_d;
         off_q         <= off_d;
         wreg_q        <= wreg_d;
         regwrite_q    <= regwrite_d;
         dm_req_q      <= dm_req_d;
         dm_we_q       <= dm_we_d;
         dm_addr_q     <= dm_addr_d;
         dm_be_q       <= dm_be_d;
         dm_wdata_q    <= dm_wdata_d;
         wb_valid_q    <= wb_valid_d;
         wb_reg_q      <= wb_reg_d;
         wb_regwrite_q <= wb_regwrite_d;
         wb_data_q     <= wb_data_d;
         wb_err_q      <= wb_err_d;
      end
   end

endmodule

// File: doc/mem_stage_hs.md
MEM_STAGE_HS -- requirements
Module: mem_stage_hs

Interface
REQ-001 SHALL have parameter BIG_ENDIAN, default 1; 1 = byte offset 0 in bits [31:24], 0 = byte offset 0 in bits [7:0].
REQ-002 SHALL have parameter TIMEOUT, default 256; the maximum number of cycles to wait for dm_ack, with legal range 2..65535.
REQ-003 SHALL have port CLK, input, 1 bit: clock; all state changes on the rising edge.
REQ-004 SHALL have port RESET, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: the upstream instruction is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: the stage accepts an instruction; low means upstream stalls.
REQ-007 SHALL have port op, input, 4 bits: 0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; codes 9-15 are treated as NONE.
REQ-008 SHALL have port alu_result, input, 32 bits: the memory byte address, or the pass-through result for NONE.
REQ-009 SHALL have port store_data, input, 32 bits: the store source register value.
REQ-010 SHALL have ports wreg (input, 5 bits) and regwrite (input, 1 bit): the destination register and its write enable.
REQ-011 SHALL have data-memory ports: dm_req out 1; dm_we out 1; dm_addr out 32 (word-aligned, [1:0]=0); dm_be out 4; dm_wdata out 32; dm_ack in 1; dm_rdata in 32 (valid when dm_ack=1).
REQ-012 SHALL have writeback ports, all outputs: wb_valid 1; wb_reg 5; wb_regwrite 1; wb_data 32; wb_err 2 (0 ok, 1 misaligned, 2 timeout).

Function
REQ-013 SHALL implement a state machine with states IDLE and WAIT; in_ready = (state==IDLE).
REQ-014 SHALL accept an instruction on a rising edge with in_valid=1 and in_ready=1, and latch op, alu_result, store_data, wreg and regwrite at that edge.
REQ-015 SHALL, for an accepted NONE op, stay in IDLE and at the same edge set wb_valid=1, wb_data=alu_result, wb_reg=wreg, wb_regwrite=regwrite, wb_err=0.
REQ-016 SHALL treat LH, LHU and SH with addr[0]=1, and LW and SW with addr[1:0]!=0, as misaligned: no DM request, and at the accept edge wb_valid=1, wb_err=1, wb_regwrite=0.
REQ-017 SHALL, for an accepted aligned memory op, move to WAIT and drive dm_req=1 continuously from the following cycle until dm_ack is sampled high or the timeout fires.
REQ-018 SHALL hold dm_addr={addr[31:2],2'b00}, dm_we, dm_be and dm_wdata stable whenever dm_req=1.
REQ-019 SHALL define lane(k) for byte offset k as bits [31-8k:24-8k] with be bit 3-k when BIG_ENDIAN=1, and as bits [8k+7:8k] with be bit k when BIG_ENDIAN=0.
REQ-020 SHALL drive stores as follows: SB replicates store_data[7:0] into all lanes with one-hot dm_be at lane(k); SH replicates store_data[15:0] with dm_be covering lanes k and k+1; SW uses dm_wdata=store_data and dm_be=4'b1111.
REQ-021 SHALL drive loads with dm_we=0 and dm_be=4'b1111; the byte for LB/LBU is lane(k), and the halfword for LH/LHU is lane(k) concatenated with lane(k+1), with lane(k) as the MSB when BIG_ENDIAN=1 and as the LSB otherwise.
REQ-022 SHALL sign-extend the loaded value for LB and LH, and zero-extend it for LBU and LHU.
REQ-023 SHALL, on the edge where dm_ack=1 in WAIT, return to IDLE and set wb_valid=1, wb_err=0, and wb_data = the extracted load value (loads) or 0 (stores).
REQ-024 SHALL set wb_regwrite to the latched regwrite for loads and to 0 for stores.
REQ-025 SHALL use a wait counter that clears on entry to WAIT and increments every WAIT cycle without dm_ack.
REQ-026 SHALL, when the wait counter reaches TIMEOUT-1 with no dm_ack, drop dm_req, return to IDLE, and set wb_valid=1, wb_err=2, wb_regwrite=0.
REQ-027 SHALL give dm_ack priority over the timeout when both occur in the same cycle.
REQ-028 SHALL ignore dm_ack while in IDLE.
REQ-029 SHALL drive wb_valid high for exactly one cycle per completed instruction, and hold wb_reg, wb_data and wb_err until the next completion.
REQ-030 SHALL make minimum latency 1 edge for NONE and misaligned ops, and 2 edges for memory ops (accept edge, then ack edge).

Reset
REQ-031 SHALL, while RESET=0, immediately force state=IDLE, wait counter=0, dm_req=0, dm_we=0, dm_be=0, dm_addr=0, dm_wdata=0, wb_valid=0, wb_regwrite=0, wb_reg=0, wb_data=0 and wb_err=0.
REQ-032 SHALL abandon any in-flight request on reset assertion in WAIT, with no writeback produced for it.
REQ-033 SHALL assert in_ready=1 in the first cycle after RESET deasserts.

Verification
REQ-034 SHALL cover, with BIG_ENDIAN=1: LB at addr 0x101 with ack after 3 cycles returning dm_rdata 0x11_80_33_44 -> dm_addr=0x100, dm_be=4'b1111, wb_data=0xFFFFFF80, wb_valid one cycle.
REQ-035 SHALL cover: SH at 0x202 with store_data 0xAAAA1234 -> dm_addr=0x200, dm_be=4'b0011, dm_wdata=0x12341234, dm_we=1; on ack wb_regwrite=0.
REQ-036 SHALL cover: LW at 0x105 -> no dm_req; next edge wb_valid=1, wb_err=1, wb_regwrite=0.
REQ-037 SHALL cover, with TIMEOUT=4: LW with no ack -> dm_req high 4 cycles, then wb_err=2, in_ready=1.
REQ-038 SHALL cover: RESET pulsed low in WAIT, followed by a late dm_ack -> no wb_valid, dm_req=0, in_ready=1.
REQ-039 SHALL cover, with BIG_ENDIAN=0: LHU at 0x2 with dm_rdata 0xBEEF0000 -> wb_data=0x0000BEEF.
